pdm_capture: RTL and testbench

- Front end of the PCM microphone path.
- Generates the clock for a PDM MEMS microphone and samples its 1-bit stream.
- Decimates the stream by counting ones over a fixed window of 2^DBITS bits.
- Writes each resulting unsigned PCM sample into the downstream audio FIFO using the FIFO's wr/din/full interface.

---
 rtl/pdm_capture_pkg.sv | 24 ++
 rtl/pdm_capture_if.sv | 15 +
 rtl/pdm_capture_clk_gen.sv | 45 ++++
 rtl/pdm_capture.sv | 129 ++++++++++++
 tb/tb_pdm_capture.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/pdm_capture_pkg.sv
// pdm_pkg: shared types and constants for the PDM microphone capture front end.
//   state_t      - capture FSM states (IDLE, RUN)
//   DIV_DEFAULT  - system clocks per half-period of mic_clk
//   DBITS_DEFAULT- PCM sample width; window length is 2^DBITS PDM bits
//   clamp_count  - saturates a window ones-count to the largest DBITS-bit value
package pdm_pkg;

  localparam int DIV_DEFAULT   = 25;
  localparam int DBITS_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A window of all ones counts to 2^dbits, one more than dout can hold.
  function automatic logic [15:0] clamp_count(input logic [16:0] count, input int dbits);
    logic [16:0] max_val;
    max_val = (17'd1 << dbits) - 17'd1;
    if (count > max_val) return max_val[15:0];
    return count[15:0];
  endfunction

endpackage

// File: rtl/pdm_capture_if.sv
// pdm_capture_if: write side of the downstream audio FIFO.
//   wr   - one-cycle write strobe (capture -> FIFO)
//   dout - PCM sample presented on FIFO din (capture -> FIFO)
//   full - FIFO full flag (FIFO -> capture)
// master: the capture block; slave: the FIFO.
interface pdm_capture_if #(
  parameter int DBITS = pdm_pkg::DBITS_DEFAULT
);
  logic             wr;
  logic [DBITS-1:0] dout;
  logic             full;

  modport master (output wr, output dout, input full);
  modport slave  (input wr, input dout, output full);
endinterface

// File: rtl/pdm_capture_clk_gen.sv
// pdm_clk_gen: microphone clock divider.
//   clock    in  system clock
//   reset_n  in  asynchronous active-low reset
//   run      in  divider runs while high; low clears it and parks mic_clk low
//   mic_clk  out divided clock, DIV cycles high / DIV cycles low
//   rise_evt out single-cycle pulse in the cycle mic_clk has just gone 0->1
module pdm_clk_gen #(
  parameter int DIV = 25
) (
  input  logic clock,
  input  logic reset_n,
  input  logic run,
  output logic mic_clk,
  output logic rise_evt
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(DIV - 1));

  // rise_evt is registered alongside mic_clk so both change on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      mic_clk  <= 1'b0;
      rise_evt <= 1'b0;
    end else if (!run) begin
      div_cnt  <= '0;
      mic_clk  <= 1'b0;
      rise_evt <= 1'b0;
    end else begin
      rise_evt <= wrap & ~mic_clk;
      if (wrap) begin
        div_cnt <= '0;
        mic_clk <= ~mic_clk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pdm_capture.sv
// pdm_capture: PDM microphone front end. Clocks the microphone, samples its
// 1-bit stream, counts ones over windows of 2^DBITS bits and writes each
// count (saturated to DBITS bits) into the audio FIFO.
//   clock     in  system clock
//   reset_n   in  asynchronous active-low reset
//   enable    in  capture enable (level)
//   mic_data  in  PDM data from the microphone
//   mic_clk   out clock to the microphone
//   mic_lrsel out L/R select, tied to left (0)
//   fifo      master port: wr, dout (to FIFO din), full
//   overrun   out sticky: a sample was dropped because full was high
// Build option: PDM_STARTUP_MUTE_EN suppresses writes for the first
// MUTE_WINDOWS windows after each enable while the microphone settles.
module pdm_capture
  import pdm_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DBITS = DBITS_DEFAULT
`ifdef PDM_STARTUP_MUTE_EN
  , parameter int MUTE_WINDOWS = 4
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        mic_data,
  output logic        mic_clk,
  output logic        mic_lrsel,
  pdm_capture_if.master fifo,
  output logic        overrun
);

  state_t state, state_next;
  logic   run, start;

  logic [1:0]       sync_q;
  logic             pdm_bit;
  logic             rise_evt;
  logic [DBITS-1:0] bit_cnt;
  logic [DBITS:0]   ones_cnt;
  logic [DBITS:0]   window_sum;
  logic             muted;

  assign mic_lrsel = 1'b0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (enable)  state_next = RUN;
      RUN:  if (!enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // run is gated by enable so the cycle enable drops already stops the
  // divider and blocks a coinciding window close.
  always_comb begin
    run   = (state == RUN) && enable;
    start = (state == IDLE) && enable;
  end

  pdm_clk_gen #(.DIV(DIV)) u_clk_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .run      (run),
    .mic_clk  (mic_clk),
    .rise_evt (rise_evt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], mic_data};
  end

  assign pdm_bit    = sync_q[1];
  assign window_sum = ones_cnt + {{DBITS{1'b0}}, pdm_bit};

`ifdef PDM_STARTUP_MUTE_EN
  localparam int MW = (MUTE_WINDOWS > 0) ? $clog2(MUTE_WINDOWS + 1) : 1;
  logic [MW-1:0] mute_cnt;

  assign muted = (mute_cnt < MW'(MUTE_WINDOWS));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                               mute_cnt <= '0;
    else if (!run)                              mute_cnt <= '0;
    else if (rise_evt && (bit_cnt == '1) && muted) mute_cnt <= mute_cnt + 1'b1;
  end
`else
  assign muted = 1'b0;
`endif

  // The last bit of a window is folded into the sum directly, so dout and wr
  // land one clock after its rise_evt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      ones_cnt  <= '0;
      fifo.wr   <= 1'b0;
      fifo.dout <= '0;
      overrun   <= 1'b0;
    end else begin
      fifo.wr <= 1'b0;
      if (start) overrun <= 1'b0;
      if (!run) begin
        bit_cnt  <= '0;
        ones_cnt <= '0;
      end else if (rise_evt) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt == '1) begin
          ones_cnt  <= '0;
          fifo.dout <= DBITS'(clamp_count(17'(window_sum), DBITS));
          if (!muted) begin
            if (fifo.full) overrun <= 1'b1;
            else           fifo.wr <= 1'b1;
          end
        end else begin
          ones_cnt <= window_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_pdm_capture.sv
// tb_pdm_capture: directed bench for pdm_capture with DIV=25, DBITS=8.
// Default build covers reset, clock timing, data extremes, backpressure,
// abort and reset during RUN; with PDM_STARTUP_MUTE_EN it covers the
// startup mute windows instead.
module tb_pdm_capture;

  localparam int DIV = 25;

  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic enable   = 1'b0;
  logic mic_data = 1'b0;
  logic mic_clk, mic_lrsel, overrun;

  int checks    = 0;
  int passes    = 0;
  int wr_count  = 0;
  int consec_wr = 0;
  logic prev_wr = 1'b0;

  pdm_capture_if #(.DBITS(8)) fifo_if ();

  pdm_capture #(.DIV(DIV), .DBITS(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .mic_data  (mic_data),
    .mic_clk   (mic_clk),
    .mic_lrsel (mic_lrsel),
    .fifo      (fifo_if.master),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  // Counts write strobes and back-to-back strobes.
  always @(negedge clock) begin
    if (fifo_if.wr) begin
      wr_count++;
      if (prev_wr) consec_wr++;
    end
    prev_wr = fifo_if.wr;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Waits for nbits mic_clk rises; optionally toggles mic_data after each.
  task automatic applyStimulus(input int nbits, input bit toggle);
    int rises = 0;
    int budget;
    logic prev;
    prev   = mic_clk;
    budget = nbits * 2 * DIV + 4 * DIV;
    while (rises < nbits && budget > 0) begin
      @(negedge clock);
      budget--;
      if (mic_clk && !prev) begin
        rises++;
        if (toggle) mic_data = ~mic_data;
      end
      prev = mic_clk;
    end
    if (rises != nbits) checkOutput("rise_timeout", rises, nbits);
  endtask

  initial begin
    int n;
    fifo_if.full = 1'b0;
    mic_data     = 1'b1;
`ifdef PDM_STARTUP_MUTE_EN
    fifo_if.full = 1'b1;
`endif
    repeat (3) @(negedge clock);
    checkOutput("rst_mic_clk", mic_clk, 0);
    checkOutput("rst_wr", fifo_if.wr, 0);
    checkOutput("rst_dout", fifo_if.dout, 8'h00);
    checkOutput("rst_overrun", overrun, 0);
    checkOutput("lrsel", mic_lrsel, 0);

    // One cycle to reach RUN, then DIV cycles to the first rise.
    enable  = 1'b1;
    reset_n = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!mic_clk && n < 200);
    checkOutput("first_rise", n, 1 + DIV);

    n = 0;
    while (mic_clk && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("clk_high", n, DIV);
    n = 0;
    while (!mic_clk && n < 200) begin
      @(negedge clock);
      n++;
    end
    checkOutput("clk_low", n, DIV);

    // Two rises consumed so far; finish the first window.
    applyStimulus(254, 1'b0);

`ifdef PDM_STARTUP_MUTE_EN
    @(negedge clock);
    checkOutput("mute_w1_wr", fifo_if.wr, 0);
    checkOutput("mute_w1_overrun", overrun, 0);
    for (int w = 2; w <= 4; w++) begin
      applyStimulus(256, 1'b0);
      @(negedge clock);
      checkOutput("mute_wr", fifo_if.wr, 0);
      checkOutput("mute_overrun", overrun, 0);
    end
    fifo_if.full = 1'b0;
    applyStimulus(256, 1'b0);
    @(negedge clock);
    checkOutput("w5_wr", fifo_if.wr, 1);
    checkOutput("w5_dout", fifo_if.dout, 8'hFF);
    @(negedge clock);
    #1;
    checkOutput("mute_wr_count", wr_count, 1);
`else
    @(negedge clock);
    checkOutput("ones_wr", fifo_if.wr, 1);
    checkOutput("ones_dout", fifo_if.dout, 8'hFF);
    @(negedge clock);
    checkOutput("wr_single", fifo_if.wr, 0);

    mic_data     = 1'b0;
    fifo_if.full = 1'b1;
    applyStimulus(256, 1'b0);
    @(negedge clock);
    checkOutput("full_no_wr", fifo_if.wr, 0);
    checkOutput("full_overrun", overrun, 1);
    checkOutput("zeros_dout", fifo_if.dout, 8'h00);

    fifo_if.full = 1'b0;
    mic_data     = 1'b1;
    applyStimulus(256, 1'b1);
    @(negedge clock);
    checkOutput("alt_wr", fifo_if.wr, 1);
    checkOutput("alt_dout", fifo_if.dout, 8'h80);
    checkOutput("overrun_sticky", overrun, 1);

    enable = 1'b0;
    repeat (2) @(negedge clock);
    enable = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("overrun_clear", overrun, 0);
    #1;
    checkOutput("wr_count_a", wr_count, 2);

    mic_data = 1'b0;
    applyStimulus(100, 1'b0);
    enable = 1'b0;
    @(negedge clock);
    checkOutput("abort_clk_low", mic_clk, 0);
    repeat (10) @(negedge clock);
    enable   = 1'b1;
    mic_data = 1'b1;
    applyStimulus(256, 1'b0);
    @(negedge clock);
    checkOutput("fresh_wr", fifo_if.wr, 1);
    checkOutput("fresh_dout", fifo_if.dout, 8'hFF);
    @(negedge clock);
    #1;
    checkOutput("wr_total", wr_count, 3);
    checkOutput("no_consec_wr", consec_wr, 0);

    applyStimulus(1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun_mic_clk", mic_clk, 0);
    checkOutput("midrun_wr", fifo_if.wr, 0);
    checkOutput("midrun_dout", fifo_if.dout, 8'h00);
    checkOutput("midrun_overrun", overrun, 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
